exp_taylor_seq: RTL and testbench

//   Sequential fixed-point e^x unit using a truncated Taylor series: sum of x^k/k! for k = 0..N_TERMS-1.

---
 rtl/exp_taylor_seq.sv | 98 +++++++++
 tb/tb_exp_taylor_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/exp_taylor_seq.sv
// exp_taylor_seq: sequential fixed-point e^x via truncated Taylor series on one shared multiplier
module exp_taylor_seq #(
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int N_TERMS = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_ovf
);
    localparam int KW = $clog2(N_TERMS);
    localparam logic signed [DATA_W-1:0] MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

    typedef enum logic [1:0] {IDLE, MULX, MULR, DONE} state_t;
    state_t state, state_nx;

    logic signed [DATA_W-1:0]   x, term, t1, sum, op_a, op_b, mul_y;
    logic signed [2*DATA_W-1:0] prod, sh;
    logic signed [DATA_W:0]     sum_ext;
    logic [KW-1:0]              k;
    logic                       ovf, sat, mul_ovf, sum_ovf, last;
    logic signed [DATA_W-1:0]   recip_tab [N_TERMS];

    assign recip_tab[0] = '0;
    for (genvar g = 1; g < N_TERMS; g++) begin : g_recip
        assign recip_tab[g] = DATA_W'(((64'sd1 <<< FRAC_W) + 64'(g / 2)) / 64'(g));
    end

    // MULX computes term*x, MULR computes t1*(1/k); both share this multiplier
    always_comb begin
        op_a     = (state == MULX) ? term : t1;
        op_b     = (state == MULX) ? x : recip_tab[k];
        prod     = op_a * op_b;
        sh       = prod >>> FRAC_W;
        mul_ovf  = !(&sh[2*DATA_W-1:DATA_W-1] || ~|sh[2*DATA_W-1:DATA_W-1]);
        mul_y    = mul_ovf ? (sh[2*DATA_W-1] ? MIN : MAX) : sh[DATA_W-1:0];
        sum_ext  = {sum[DATA_W-1], sum} + {mul_y[DATA_W-1], mul_y};
        sum_ovf  = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
        last     = (k == KW'(N_TERMS - 1));
        state_nx = (state == IDLE && in_valid) ? MULX :
                   (state == MULX)             ? MULR :
                   (state == MULR)             ? (last ? DONE : MULX) :
                   (state == DONE && out_ready) ? IDLE : state;
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        out_y     = (state == DONE && !sum[DATA_W-1]) ? sum : '0;
        out_ovf   = (state == DONE) && ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            term <= '0;
            t1   <= '0;
            sum  <= '0;
            k    <= '0;
            ovf  <= 1'b0;
            sat  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    x    <= in_x;
                    term <= ONE;
                    sum  <= ONE;
                    k    <= KW'(1);
                    ovf  <= 1'b0;
                    sat  <= 1'b0;
                end
                MULX: begin
                    t1  <= mul_y;
                    ovf <= ovf | mul_ovf;
                end
                MULR: begin
                    term <= mul_y;
                    // a saturated sum stays pinned at MAX for the rest of the operation
                    sum  <= (sat || sum_ovf) ? MAX : sum_ext[DATA_W-1:0];
                    sat  <= sat | sum_ovf;
                    ovf  <= ovf | mul_ovf | sum_ovf;
                    if (!last) k <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exp_taylor_seq.sv
// tb_exp_taylor_seq: scoreboard bench for exp_taylor_seq with a plain-arithmetic Taylor reference
module tb_exp_taylor_seq;
    localparam int N = 21;
    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, out_ovf;
    logic [31:0] in_x = 0, out_y;

    exp_taylor_seq #(.DATA_W(32), .FRAC_W(16), .N_TERMS(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint y;
        longint tol;
        bit     ovf;
        int     acc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0, total = 0, bad = 0;
    bit   prev_v = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint expv, input longint tol);
        longint d = act - expv;
        total++;
        if (d > tol || d < -tol) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (tol %0d)", nm, act, expv, tol);
        end
    endtask

    function automatic longint clampv(input longint v, inout bit o);
        if (v > LMAX) begin o = 1; return LMAX; end
        if (v < LMIN) begin o = 1; return LMIN; end
        return v;
    endfunction

    // e^x as sum of x^k/k!, terms built recursively with rounded reciprocals
    task automatic model(input logic [31:0] xin, output longint y, output bit o);
        longint xs = longint'($signed(xin));
        longint term = 65536, sum = 65536, t1, s, r;
        bit sat = 0;
        o = 0;
        for (int k = 1; k < N; k++) begin
            r    = ((64'sd1 << 16) + k / 2) / k;
            t1   = clampv((term * xs) >>> 16, o);
            term = clampv((t1 * r) >>> 16, o);
            s    = sum + term;
            if (sat || s > LMAX || s < LMIN) begin
                if (s > LMAX || s < LMIN) o = 1;
                sat = 1;
                sum = LMAX;
            end else sum = s;
        end
        y = (sum < 0) ? 0 : sum;
    endtask

    always @(negedge clk) begin
        if (rst) prev_v = 0;
        else begin
            if (out_valid && !prev_v) begin
                if (q.size() != 1) chk("queue_depth", q.size(), 1, 0);
                else chk("latency", cyc - q[0].acc, 40, 0);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("out_y", out_y, e.y, e.tol);
                chk("out_ovf", out_ovf, e.ovf, 0);
            end
            prev_v = out_valid;
        end
    end

    task automatic send(input logic [31:0] x, input longint ry, input longint tol, input bit ro);
        int n = 0;
        exp_t t;
        @(negedge clk);
        in_valid = 1;
        in_x = x;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", 0, 1, 0);
        @(posedge clk); #1;
        in_valid = 0;
        t.y = ry; t.tol = tol; t.ovf = ro; t.acc = cyc;
        q.push_back(t);
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        if (!out_valid) chk("valid_timeout", 0, 1, 0);
    endtask

    task automatic run(input logic [31:0] x, input longint ry, input longint tol, input bit ro, input int stall);
        send(x, ry, tol, ro);
        wait_valid();
        repeat (stall) @(negedge clk);
        @(posedge clk); #1 out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
    endtask

    task automatic run_model(input logic [31:0] x, input int stall);
        longint y;
        bit o;
        model(x, y, o);
        run(x, y, 0, o, stall);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] y0;
        logic [31:0] rx;
        #12;
        chk("rst_out_valid", out_valid, 0, 0);
        chk("rst_out_y", out_y, 0, 0);
        chk("rst_out_ovf", out_ovf, 0, 0);
        chk("rst_in_ready", in_ready, 0, 0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        chk("ready_after_rst", in_ready, 1, 0);

        run(32'h0000_0000, 32'h0001_0000, 0, 0, 0);
        run(32'h0001_0000, 178145, 8, 0, 1);
        run(32'hFFFF_0000, 24109, 8, 0, 2);
        run(32'h000B_0000, 32'h7FFF_FFFF, 0, 1, 0);
        run(32'h0000_0000, 32'h0001_0000, 0, 0, 0);

        send(32'h0000_8000, 108051, 8, 0);
        wait_valid();
        y0 = out_y;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1, 0);
            chk("bp_y", out_y, y0, 0);
            chk("bp_in_ready", in_ready, 0, 0);
        end
        @(posedge clk); #1 out_ready = 1;
        chk("in_ready_before_hs", in_ready, 0, 0);
        @(posedge clk); #1 out_ready = 0;
        chk("in_ready_after_hs", in_ready, 1, 0);

        send(32'h0000_8000, 0, 0, 0);
        repeat (14) @(posedge clk);
        #1 rst = 1;
        #1;
        q.delete();
        chk("abort_valid", out_valid, 0, 0);
        chk("abort_y", out_y, 0, 0);
        chk("abort_in_ready", in_ready, 0, 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        chk("abort_ready_after", in_ready, 1, 0);
        run(32'h0001_0000, 178145, 8, 0, 0);

        for (int i = 0; i < 25; i++) begin
            rx = 32'($urandom_range(0, 6 * 65536)) - 32'd196608;
            run_model(rx, $urandom_range(0, 3));
        end
        for (int i = 0; i < 5; i++) run_model($urandom, $urandom_range(0, 2));
        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
